instr_fetch_queue: RTL
======================

# instr_fetch_queue

Upstream fetch stage for the single-cycle RISC-V core. It replaces the direct PC-to-instruction-memory path. It owns the fetch PC and issues in-order requests to a latency-tolerant instruction memory. Returned words are buffered in a small queue, and each instruction is presented to the datapath with a valid/ready handshake together with its PC and PC+4. Branch and jump targets from the datapath arrive on a redirect port, which flushes all younger work.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response word valid; responses return in order, latency ≥1 cycle
- imem_rsp_data  in  32  instruction word
- redirect  in  1  taken branch/jump; pulse, one cycle
- redirect_pc  in  32  new fetch target (pc_target from datapath)
- out_valid  out  1  head instruction available
- out_ready  in  1  datapath consumes head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  PC of head instruction
- out_pc_plus_4  out  32  out_pc + 4, mod 2^32

## Operation
- Fetch PC register `fetch_pc` holds the next address to request.
  - imem_addr = fetch_pc.
  - On an accepted request (req_valid & req_ready), fetch_pc += 4, wrapping 0xFFFF_FFFC → 0x0000_0000.
- Credit rule: imem_req_valid = !redirect & (occupancy + outstanding < DEPTH).
  - A response therefore never finds the queue full.
- `outstanding` counts accepted requests whose responses have not returned. Width is clog2(DEPTH)+1.
- Response handling:
  - If `drop_cnt` > 0, the response is discarded and drop_cnt decrements.
  - Otherwise the response is pushed with its PC, taken from a PC side-FIFO (or computed from a tail PC register). The PC stays paired with its word.
- Pop: out_valid & out_ready removes the head. The output fields are the head entry and are combinational from queue storage.
- Redirect (highest priority, the same cycle it is asserted):
  - Queue is emptied; occupancy becomes 0.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - drop_cnt ← outstanding (after this cycle's accepted/returned updates), so every in-flight old response is discarded.
  - A response arriving in the redirect cycle is dropped and is not counted in the new drop_cnt.
  - No request is issued in the redirect cycle.
  - A concurrent pop is ignored, since the queue is cleared anyway.
- Fetching resumes the cycle after the redirect. New-path responses are accepted only once drop_cnt reaches 0. In-order return guarantees correctness.

## Timing
- Reset values:
  - fetch_pc = RESET_PC
  - occupancy = outstanding = drop_cnt = 0
  - out_valid = 0, imem_req_valid = 0 while reset is low
  - out_instr = out_pc = 0, out_pc_plus_4 = 4
- First request: the first clk edge after reset deasserts with imem_req_valid = 1.
- Latency: a response in cycle N gives out_valid = 1 in N+1. There is no bypass from rsp to out.
- Throughput: one instruction per cycle, provided memory latency ≤ DEPTH-1.
- Simultaneous push and pop keeps occupancy unchanged. The queue is never pushed when full (guaranteed by the credit rule). Pop is never honoured when empty.
- imem_req_valid may drop without acceptance; the team's memory is not allowed to rely on stable requests.
- Asserting reset mid-operation clears everything immediately. Responses arriving after reset are ignored, because outstanding = 0 and the queue only accepts responses while outstanding > 0.

## Structure
- Package `fetch_pkg`:
  - fetch_entry_t struct {instr[31:0], pc[31:0]}
  - RESET_PC default constant
  - NOP_INSTR = 32'h0000_0013, for bench idle fill
- Sub-module `fetch_fifo`: parameterised DEPTH × fetch_entry_t circular buffer.
  - Ports: push, pop, flush, full, empty, count, head.
  - Pointers wrap mod DEPTH; count is 0..DEPTH.
- Top level holds fetch_pc, the outstanding/drop counters, credit logic and redirect priority.

## Test plan
- Reset, memory with 1-cycle latency, out_ready = 1: out_pc sequence is 0x0, 0x4, 0x8…, one per cycle starting 2 cycles after reset release, and out_pc_plus_4 = out_pc + 4.
- out_ready = 0 for 10 cycles: exactly DEPTH = 4 requests are issued, and req_valid stays low until a pop. After release, PCs continue with no gap or duplicate.
- Memory latency of 3 cycles with 2 requests in flight, then redirect to 0x0000_0102: both old responses are dropped, and the next out_pc = 0x0000_0100.
- Redirect in the same cycle as rsp_valid and out_ready: the response is dropped, the pop is ignored, and out_valid = 0 in the next cycle.
- RESET_PC = 0xFFFF_FFF8: fetch order is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; out_pc_plus_4 = 0 at 0xFFFF_FFFC.
- reset pulled low while 2 requests are outstanding: outputs return to their reset values asynchronously, and later stale responses are not enqueued.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// fetch_pkg: shared entry type and constants for the instruction fetch queue.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: instruction-memory, redirect and datapath handshakes of the fetch stage.
interface instr_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  modport master (
    output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of instruction/PC pairs with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           entry_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Storage is reset so the head fields read as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= entry_i;
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, issues credit-limited imem requests and
// buffers in-order responses for the datapath; redirects flush all younger work.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  instr_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, tail_pc_q, tail_pc_d, redir_pc;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
  logic          full, empty, req_fire, rsp_ok, push, pop;
  fetch_entry_t  head, push_entry;
  assign redir_pc           = {bus.redirect_pc[31:2], 2'b00};
  assign bus.imem_req_valid = rst_ni & ~bus.redirect &
                              (({1'b0, count} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
  assign bus.imem_addr      = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  // Responses only count while something is in flight, so stale ones after reset are ignored.
  assign rsp_ok             = bus.imem_rsp_valid & (outst_q != '0);
  assign push               = rsp_ok & (drop_q == '0) & ~bus.redirect & ~full;
  assign pop                = bus.out_ready & ~empty & ~bus.redirect;
  assign push_entry         = '{instr: bus.imem_rsp_data, pc: tail_pc_q};
  assign bus.out_valid      = ~empty;
  assign bus.out_instr      = head.instr;
  assign bus.out_pc         = head.pc;
  assign bus.out_pc_plus_4  = head.pc + 32'd4;
  // tail_pc tracks the PC of the next response that will be kept, so no PC side-FIFO is needed.
  always_comb begin
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_ok);
    drop_d     = bus.redirect ? outst_d : drop_q - CW'(rsp_ok && drop_q != '0);
    fetch_pc_d = bus.redirect ? redir_pc : fetch_pc_q + (req_fire ? 32'd4 : 32'd0);
    tail_pc_d  = bus.redirect ? redir_pc : tail_pc_q + (push ? 32'd4 : 32'd0);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      tail_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tail_pc_q  <= tail_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .entry_i (push_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );
endmodule
